// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a run-time loadable pattern, overlapping or
// restart-after-match modes, a saturating match counter and a progress output.
module seq_pattern_detector #(
    parameter int unsigned                PAT_LEN     = 6,
    parameter logic        [PAT_LEN-1:0]  DEFAULT_PAT = 6'b010110,
    parameter int unsigned                CNT_W       = 8,
    parameter int unsigned                ST_W        = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               x,
    input  logic               m,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               clr_cnt,
    output logic               z,
    output logic [ST_W-1:0]    state,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int unsigned          FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               z_q,    z_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;

    logic [PAT_LEN-1:0] h_nxt;
    logic [FILL_W-1:0]  f_nxt;
    logic               hit;

    // Longest prefix of the pattern that the newest history bits already match.
    function automatic logic [ST_W-1:0] progress(
        input logic [PAT_LEN-1:0] h,
        input logic [FILL_W-1:0]  f,
        input logic [PAT_LEN-1:0] p
    );
        logic [ST_W-1:0]    best;
        logic [PAT_LEN-1:0] mask;
        logic [PAT_LEN-1:0] top;
        best = '0;
        mask = '0;
        for (int k = 1; k <= int'(PAT_LEN); k++) begin
            mask = {mask[PAT_LEN-2:0], 1'b1};
            top  = p >> (PAT_LEN - k);
            if ((int'(f) >= k) && (((h ^ top) & mask) == '0)) begin
                best = ST_W'(k);
            end
        end
        return best;
    endfunction

    assign h_nxt = {hist_q[PAT_LEN-2:0], x};
    assign f_nxt = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    assign hit   = en && !load && (f_nxt == FILL_MAX) && (h_nxt == pat_q);

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = 1'b0;
        cnt_d  = cnt_q;
        if (load) begin
            pat_d  = pattern_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            if (hit) begin
                z_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (hit && m) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = h_nxt;
                fill_d = f_nxt;
            end
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_q  <= DEFAULT_PAT;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
        end
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign state     = progress(hist_q, fill_q, pat_q);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_seq_pattern_detector;

    logic       clk;
    logic       reset;
    logic       en;
    logic       x;
    logic       m;
    logic       load;
    logic [5:0] pattern_in;
    logic       clr_cnt;
    logic       z_a,  z_b;
    logic [2:0] st_a, st_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    seq_pattern_detector #(.PAT_LEN(6), .DEFAULT_PAT(6'b010110), .CNT_W(8), .ST_W(3)) dut_a (
        .clk(clk), .reset(reset), .en(en), .x(x), .m(m), .load(load),
        .pattern_in(pattern_in), .clr_cnt(clr_cnt),
        .z(z_a), .state(st_a), .match_cnt(cnt_a)
    );

    seq_pattern_detector #(.PAT_LEN(6), .DEFAULT_PAT(6'b010110), .CNT_W(2), .ST_W(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .x(x), .m(m), .load(load),
        .pattern_in(pattern_in), .clr_cnt(clr_cnt),
        .z(z_b), .state(st_b), .match_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic b);
        en = e;
        x  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [5:0] p, input logic clr);
        load       = 1'b1;
        pattern_in = p;
        clr_cnt    = clr;
        step(1'b1, 1'b1);
        load    = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic send6(input string tag, input logic [5:0] bits,
                         input logic [23:0] exp_st, input logic [5:0] exp_z);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, bits[5-i]);
            check({tag, "_z"}, int'(z_a), int'(exp_z[5-i]));
            check({tag, "_state"}, int'(st_a), int'(exp_st[23-4*i -: 4]));
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; x = 1'b0; m = 1'b0;
        load = 1'b0; pattern_in = '0; clr_cnt = 1'b0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_z", int'(z_a), 0);
            check("rst_cnt", int'(cnt_a), 0);
            check("rst_state", int'(st_a), 0);
        end
        reset = 1'b1;

        // Default pattern, non-overlapping
        m = 1'b1;
        send6("dflt", 6'b010110, 24'h123450, 6'b000001);
        check("dflt_cnt", int'(cnt_a), 1);
        step(1'b0, 1'b0);
        check("dflt_pulse_end", int'(z_a), 0);
        check("dflt_cnt_hold", int'(cnt_a), 1);

        // Overlapping mode with 101101
        do_load(6'b101101, 1'b1);
        check("ld_state", int'(st_a), 0);
        check("ld_cnt", int'(cnt_a), 0);
        m = 1'b0;
        send6("ovl", 6'b101101, 24'h123456, 6'b000001);
        step(1'b1, 1'b1); check("ovl7_z", int'(z_a), 0); check("ovl7_st", int'(st_a), 4);
        step(1'b1, 1'b0); check("ovl8_z", int'(z_a), 0); check("ovl8_st", int'(st_a), 5);
        step(1'b1, 1'b1); check("ovl9_z", int'(z_a), 1); check("ovl9_st", int'(st_a), 6);
        check("ovl_cnt", int'(cnt_a), 2);
        step(1'b0, 1'b0); check("ovl_pulse_end", int'(z_a), 0);

        // Non-overlapping mode, same stream
        do_load(6'b101101, 1'b1);
        m = 1'b1;
        send6("novl", 6'b101101, 24'h123450, 6'b000001);
        step(1'b1, 1'b1); check("novl7_z", int'(z_a), 0); check("novl7_st", int'(st_a), 1);
        step(1'b1, 1'b0); check("novl8_z", int'(z_a), 0); check("novl8_st", int'(st_a), 2);
        step(1'b1, 1'b1); check("novl9_z", int'(z_a), 0); check("novl9_st", int'(st_a), 3);
        check("novl_cnt", int'(cnt_a), 1);

        // en bubbles with x toggling
        do_load(6'b010110, 1'b1);
        begin
            logic [5:0]  bits;
            logic [23:0] est;
            bits = 6'b010110;
            est  = 24'h123450;
            for (int i = 0; i < 6; i++) begin
                step(1'b1, bits[5-i]);
                check("gate_z", int'(z_a), (i == 5) ? 1 : 0);
                check("gate_st", int'(st_a), int'(est[23-4*i -: 4]));
                step(1'b0, ~bits[5-i]);
                check("bubble_z", int'(z_a), 0);
                check("bubble_st", int'(st_a), int'(est[23-4*i -: 4]));
            end
        end
        check("gate_cnt", int'(cnt_a), 1);

        // Load in the middle of a stream
        step(1'b1, 1'b0); check("mid1_st", int'(st_a), 1);
        step(1'b1, 1'b1); check("mid2_st", int'(st_a), 2);
        step(1'b1, 1'b0); check("mid3_st", int'(st_a), 3);
        step(1'b1, 1'b1); check("mid4_st", int'(st_a), 4);
        do_load(6'b111000, 1'b0);
        check("midld_st", int'(st_a), 0);
        check("midld_z", int'(z_a), 0);
        send6("newpat", 6'b111000, 24'h123450, 6'b000001);

        // Counter saturation on the 2-bit instance
        do_load(6'b010110, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send6("sat", 6'b010110, 24'h123450, 6'b000001);
            check("sat_cnt8", int'(cnt_a), i + 1);
            check("sat_cnt2", int'(cnt_b), (i + 1 > 3) ? 3 : i + 1);
        end

        // Clear on the same cycle as a completing bit
        step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        clr_cnt = 1'b1;
        step(1'b1, 1'b0);
        clr_cnt = 1'b0;
        check("clrhit_z", int'(z_a), 1);
        check("clrhit_cnt8", int'(cnt_a), 0);
        check("clrhit_cnt2", int'(cnt_b), 0);

        // Reset asserted between edges with a pulse pending
        do_load(6'b111000, 1'b0);
        m = 1'b0;
        send6("prerst", 6'b111000, 24'h123456, 6'b000001);
        check("prerst_cnt", int'(cnt_a), 1);
        reset = 1'b0;
        #3;
        check("rstmid_z", int'(z_a), 1);
        check("rstmid_st", int'(st_a), 6);
        check("rstmid_cnt", int'(cnt_a), 1);
        @(posedge clk);
        #1;
        check("rstedge_z", int'(z_a), 0);
        check("rstedge_st", int'(st_a), 0);
        check("rstedge_cnt", int'(cnt_a), 0);
        reset = 1'b1;
        m = 1'b1;
        send6("postrst", 6'b010110, 24'h123450, 6'b000001);
        check("postrst_cnt", int'(cnt_a), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
